// File: rtl/brick_map.sv
// Breakout brick wall: 25-brick live map, hit scoring, level refill
// and a two-stage pixel lookup feeding the VGA renderer.
module brick_map #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int BLOCK_WIDTH     = 80,
  parameter int BLOCK_SPACING_X = 40,
  parameter int BLOCK_HEIGHT    = 30,
  parameter int FIRST_ROW_Y     = 40,
  parameter int ROW_PITCH       = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        erase_enable,
  input  logic [5:0]  e_pos,
  input  logic        new_level,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        brick_on,
  output logic [2:0]  brick_row,
  output logic [4:0]  bricks_left,
  output logic [15:0] score,
  output logic        busy,
  output logic        all_cleared
);

  localparam int COL_PITCH = BLOCK_WIDTH + BLOCK_SPACING_X;

  typedef enum logic [1:0] {
    REFILL  = 2'd0,
    PLAY    = 2'd1,
    CLEARED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [24:0] active_q, active_d;
  logic [4:0]  left_q, left_d;
  logic [15:0] score_q, score_d;
  logic        busy_q, busy_d;
  logic        clr_q, clr_d;

  logic        hit;
  logic [5:0]  pts;
  logic [16:0] sum;

  assign hit = erase_enable && (e_pos < 6'd25)
             && active_q[e_pos[4:0]];

  always_comb begin
    pts = 6'd0;
    unique case (1'b1)
      (e_pos < 6'd5):  pts = 6'd50;
      (e_pos >= 6'd5  && e_pos < 6'd10): pts = 6'd40;
      (e_pos >= 6'd10 && e_pos < 6'd15): pts = 6'd30;
      (e_pos >= 6'd15 && e_pos < 6'd20): pts = 6'd20;
      (e_pos >= 6'd20 && e_pos < 6'd25): pts = 6'd10;
      (e_pos >= 6'd25): pts = 6'd0;
    endcase
  end

  assign sum = {1'b0, score_q} + {11'd0, pts};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    active_d = active_q;
    left_d   = left_q;
    score_d  = score_q;
    busy_d   = busy_q;
    clr_d    = clr_q;
    if (new_level) begin
      state_d  = REFILL;
      k_d      = 5'd0;
      active_d = 25'd0;
      left_d   = 5'd0;
      busy_d   = 1'b1;
      clr_d    = 1'b0;
    end else begin
      unique case (state_q)
        REFILL: begin
          active_d[k_q] = 1'b1;
          left_d        = left_q + 5'd1;
          k_d           = k_q + 5'd1;
          if (k_q == 5'd24) begin
            state_d = PLAY;
            k_d     = 5'd0;
            busy_d  = 1'b0;
          end
        end
        PLAY: begin
          if (hit) begin
            active_d[e_pos[4:0]] = 1'b0;
            left_d  = left_q - 5'd1;
            score_d = sum[16] ? 16'hFFFF : sum[15:0];
            if (left_q == 5'd1) begin
              state_d = CLEARED;
              clr_d   = 1'b1;
            end
          end
        end
        CLEARED: begin
        end
        default: begin
          state_d = REFILL;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= REFILL;
      k_q      <= 5'd0;
      active_q <= 25'd0;
      left_q   <= 5'd0;
      score_q  <= 16'd0;
      busy_q   <= 1'b1;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      active_q <= active_d;
      left_q   <= left_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
    end
  end

  // Pixel stage 1: locate row/column by constant range compares.
  logic [31:0] px32, py32;
  logic [2:0]  row_c, col_c;
  logic [2:0]  row_s1_q, col_s1_q;

  assign px32 = {22'd0, pixel_x};
  assign py32 = {22'd0, pixel_y};

  always_comb begin
    row_c = 3'd7;
    col_c = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (py32 >= 32'(FIRST_ROW_Y + i * ROW_PITCH)
          && py32 < 32'(FIRST_ROW_Y + i * ROW_PITCH + BLOCK_HEIGHT)
          && py32 < 32'(SCREEN_H))
        row_c = 3'(i);
      if (px32 >= 32'(BLOCK_SPACING_X + i * COL_PITCH)
          && px32 < 32'(BLOCK_SPACING_X + i * COL_PITCH + BLOCK_WIDTH)
          && px32 < 32'(SCREEN_W))
        col_c = 3'(i);
    end
  end

  // Stage 2 looks at next-state map so an erase shows on its own edge.
  logic [4:0] idx;
  logic       on_c;

  assign idx  = ({2'd0, row_s1_q} << 2) + {2'd0, row_s1_q}
              + {2'd0, col_s1_q};
  assign on_c = (row_s1_q != 3'd7) && (col_s1_q != 3'd7)
              && active_d[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q  <= 3'd7;
      col_s1_q  <= 3'd7;
      brick_on  <= 1'b0;
      brick_row <= 3'd7;
    end else begin
      row_s1_q  <= row_c;
      col_s1_q  <= col_c;
      brick_on  <= on_c;
      brick_row <= on_c ? row_s1_q : 3'd7;
    end
  end

  assign bricks_left = left_q;
  assign score       = score_q;
  assign busy        = busy_q;
  assign all_cleared = clr_q;

endmodule
